// File: rtl/wave_capture.sv
// Triggered waveform capture: on a positive zero crossing, write 256 offset-binary
// samples into the RAM half not being displayed, then wait for display idle to swap.
module wave_capture (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_sample_ready,
   input  logic [15:0] new_sample_in,
   input  logic        wave_display_idle,
   output logic [8:0]  write_address,
   output logic        write_enable,
   output logic [7:0]  write_sample,
   output logic        read_index
);

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_index, w_index_nxt;
   logic [15:0] r_prev_sample;
   logic        r_read_index, w_read_index_nxt;
   logic [8:0]  r_write_address, w_write_address_nxt;
   logic        r_write_enable, w_write_enable_nxt;
   logic [7:0]  r_write_sample, w_write_sample_nxt;
   logic        w_crossing;

   // Rising zero crossing: previous sample negative, current sample non-negative.
   assign w_crossing = ($signed(r_prev_sample) < 16'sd0) &&
                       !($signed(new_sample_in) < 16'sd0);

   always_comb begin
      w_state_nxt         = r_state;
      w_index_nxt         = r_index;
      w_read_index_nxt    = r_read_index;
      w_write_enable_nxt  = 1'b0;
      w_write_address_nxt = r_write_address;
      w_write_sample_nxt  = r_write_sample;
      case (r_state)
         ST_ARMED: begin
            if (new_sample_ready && w_crossing) begin
               w_state_nxt = ST_ACTIVE;
               w_index_nxt = 8'd0;
            end
         end
         ST_ACTIVE: begin
            if (new_sample_ready) begin
               w_write_enable_nxt  = 1'b1;
               w_write_address_nxt = {~r_read_index, r_index};
               w_write_sample_nxt  = {~new_sample_in[15], new_sample_in[14:8]};
               w_index_nxt         = r_index + 8'd1;
               if (r_index == 8'hFF) begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // A sample arriving with idle is dropped, not tested for a crossing.
            if (wave_display_idle) begin
               w_read_index_nxt = ~r_read_index;
               w_state_nxt      = ST_ARMED;
            end
         end
         default: begin
            w_state_nxt = ST_ARMED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_ARMED;
         r_index         <= 8'd0;
         r_prev_sample   <= 16'd0;
         r_read_index    <= 1'b0;
         r_write_enable  <= 1'b0;
         r_write_address <= 9'd0;
         r_write_sample  <= 8'd0;
      end else begin
         r_state         <= w_state_nxt;
         r_index         <= w_index_nxt;
         r_read_index    <= w_read_index_nxt;
         r_write_enable  <= w_write_enable_nxt;
         r_write_address <= w_write_address_nxt;
         r_write_sample  <= w_write_sample_nxt;
         if (new_sample_ready) begin
            r_prev_sample <= new_sample_in;
         end
      end
   end

   assign write_address = r_write_address;
   assign write_enable  = r_write_enable;
   assign write_sample  = r_write_sample;
   assign read_index    = r_read_index;

endmodule
